// File: rtl/lockstep_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lockstep_pkg
// Purpose  : Shared state encodings and default limits for the lockstep
//            commit scheduler and its watchdog.
// Revision : 1.0 - initial release
// ============================================================================
package lockstep_pkg;

  // Scheduler states; the encoding is visible on the state output port.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CHECK_INIT = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;
  localparam logic [1:0] ST_FAIL       = 2'd3;

  // Default tolerances for the two cores drifting apart or stalling.
  localparam int DEFAULT_MAX_SKEW   = 4;
  localparam int DEFAULT_HANG_LIMIT = 64;

endpackage : lockstep_pkg
`default_nettype wire

// File: rtl/lockstep_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : lockstep_watchdog
// Purpose  : Saturating count of consecutive enabled cycles without any
//            retirement; flags the cycle whose count reaches LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module lockstep_watchdog #(
  parameter int LIMIT = lockstep_pkg::DEFAULT_HANG_LIMIT
) (
  input  logic clk,
  input  logic reset_x,
  input  logic en,    // count only while lockstep is running
  input  logic clr,   // some retirement happened this cycle
  output logic hit    // this idle cycle brings the count up to LIMIT
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  // Next count: clear on activity, otherwise advance and hold at LIMIT.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (clr) begin
        count_d = '0;
      end else if (count_q != W'(LIMIT)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign hit = en & ~clr & (count_q >= W'(LIMIT - 1));

  // Idle-cycle counter register.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : lockstep_watchdog
`default_nettype wire

// File: rtl/lockstep_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lockstep_commit_scheduler
// Purpose  : Keeps the OoO core and the 1-cycle ISA model in retirement
//            lockstep by stalling whichever side is ahead, signals aligned
//            check points and latches sticky failure causes.
// Revision : 1.0 - initial release
// ============================================================================
module lockstep_commit_scheduler
  import lockstep_pkg::*;
#(
  parameter int CW         = 2,
  parameter int CNT_W      = 32,
  parameter int SKEW_W     = 8,
  parameter int MAX_SKEW   = DEFAULT_MAX_SKEW,
  parameter int HANG_LIMIT = DEFAULT_HANG_LIMIT
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic             start,
  input  logic             init_match,
  input  logic             arch_match,
  input  logic [CW-1:0]    impl_comnum,
  input  logic             impl_flush,
  input  logic             spec_retire,
  output logic             impl_stall,
  output logic             spec_stall,
  output logic             aligned,
  output logic             check_valid,
  output logic             fail_init,
  output logic             fail_mismatch,
  output logic             fail_skew,
  output logic             fail_hang,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] impl_total,
  output logic [CNT_W-1:0] spec_total
);

  localparam logic signed [SKEW_W-1:0] SKEW_HI = SKEW_W'(MAX_SKEW);
  localparam logic signed [SKEW_W-1:0] SKEW_LO = -SKEW_HI;

  logic [1:0]               state_q, state_d;
  logic                     impl_stall_q, impl_stall_d;
  logic                     spec_stall_q, spec_stall_d;
  logic                     aligned_q, aligned_d;
  logic                     fail_init_q, fail_init_d;
  logic                     fail_mismatch_q, fail_mismatch_d;
  logic                     fail_skew_q, fail_skew_d;
  logic                     fail_hang_q, fail_hang_d;
  logic [CNT_W-1:0]         impl_total_q, impl_total_d;
  logic [CNT_W-1:0]         spec_total_q, spec_total_d;
  logic signed [SKEW_W-1:0] skew_q, skew_d;

  logic                     run;
  logic [CW-1:0]            impl_inc;
  logic                     spec_inc;
  logic signed [SKEW_W-1:0] skew_n;
  logic                     hang_hit;
  logic                     cv;
  logic                     bad_mismatch, bad_skew;

  assign run = (state_q == ST_RUN);
  assign cv  = aligned_q & run;

  // Only unstalled, unflushed retirements count; stalls are the registered outputs.
  assign impl_inc = (impl_stall_q | impl_flush) ? '0 : impl_comnum;
  assign spec_inc = ~spec_stall_q & spec_retire;
  assign skew_n   = skew_q
                  + $signed({{(SKEW_W-CW){1'b0}}, impl_inc})
                  - $signed({{(SKEW_W-1){1'b0}}, spec_inc});

  assign bad_mismatch = cv & ~arch_match;
  assign bad_skew     = (skew_n > SKEW_HI) | (skew_n < SKEW_LO);

  lockstep_watchdog #(
    .LIMIT (HANG_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .reset_x (reset_x),
    .en      (run),
    .clr     ((impl_inc != '0) | spec_inc),
    .hit     (hang_hit)
  );

  // FSM, accumulators and stall decisions; everything holds unless RUN advances it.
  always_comb begin
    state_d         = state_q;
    impl_stall_d    = impl_stall_q;
    spec_stall_d    = spec_stall_q;
    aligned_d       = aligned_q;
    fail_init_d     = fail_init_q;
    fail_mismatch_d = fail_mismatch_q;
    fail_skew_d     = fail_skew_q;
    fail_hang_d     = fail_hang_q;
    impl_total_d    = impl_total_q;
    spec_total_d    = spec_total_q;
    skew_d          = skew_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK_INIT;
      end
      ST_CHECK_INIT: begin
        if (init_match) begin
          state_d      = ST_RUN;
          impl_stall_d = 1'b0;
          spec_stall_d = 1'b0;
        end else begin
          state_d     = ST_FAIL;
          fail_init_d = 1'b1;
        end
      end
      ST_RUN: begin
        impl_total_d = impl_total_q + CNT_W'(impl_inc);
        spec_total_d = spec_total_q + CNT_W'(spec_inc);
        skew_d       = skew_n;
        aligned_d    = (skew_n == '0);
        // The side that is ahead waits; at zero skew both proceed.
        impl_stall_d = (skew_n > 0);
        spec_stall_d = (skew_n < 0);
        if (bad_mismatch) fail_mismatch_d = 1'b1;
        if (bad_skew)     fail_skew_d     = 1'b1;
        if (hang_hit)     fail_hang_d     = 1'b1;
        if (bad_mismatch | bad_skew | hang_hit) begin
          state_d      = ST_FAIL;
          impl_stall_d = 1'b1;
          spec_stall_d = 1'b1;
        end
      end
      default: begin
        // FAIL is terminal until reset.
      end
    endcase
  end

  // State registers; reset parks both cores stalled in IDLE.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q         <= ST_IDLE;
      impl_stall_q    <= 1'b1;
      spec_stall_q    <= 1'b1;
      aligned_q       <= 1'b1;
      fail_init_q     <= 1'b0;
      fail_mismatch_q <= 1'b0;
      fail_skew_q     <= 1'b0;
      fail_hang_q     <= 1'b0;
      impl_total_q    <= '0;
      spec_total_q    <= '0;
      skew_q          <= '0;
    end else begin
      state_q         <= state_d;
      impl_stall_q    <= impl_stall_d;
      spec_stall_q    <= spec_stall_d;
      aligned_q       <= aligned_d;
      fail_init_q     <= fail_init_d;
      fail_mismatch_q <= fail_mismatch_d;
      fail_skew_q     <= fail_skew_d;
      fail_hang_q     <= fail_hang_d;
      impl_total_q    <= impl_total_d;
      spec_total_q    <= spec_total_d;
      skew_q          <= skew_d;
    end
  end

  assign state         = state_q;
  assign impl_stall    = impl_stall_q;
  assign spec_stall    = spec_stall_q;
  assign aligned       = aligned_q;
  assign check_valid   = cv;
  assign fail_init     = fail_init_q;
  assign fail_mismatch = fail_mismatch_q;
  assign fail_skew     = fail_skew_q;
  assign fail_hang     = fail_hang_q;
  assign impl_total    = impl_total_q;
  assign spec_total    = spec_total_q;

endmodule : lockstep_commit_scheduler
`default_nettype wire

// File: tb/tb_lockstep_commit_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lockstep_commit_scheduler
// Purpose  : Directed self-checking bench for lockstep_commit_scheduler.
//            Small CNT_W, MAX_SKEW and HANG_LIMIT make wrap, skew and hang
//            reachable in a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lockstep_commit_scheduler;

  logic       clk = 1'b0;
  logic       reset_x;
  logic       start, init_match, arch_match, impl_flush, spec_retire;
  logic [1:0] impl_comnum;
  logic       impl_stall, spec_stall, aligned, check_valid;
  logic       fail_init, fail_mismatch, fail_skew, fail_hang;
  logic [1:0] state;
  logic [3:0] impl_total, spec_total;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lockstep_commit_scheduler #(
    .CW(2), .CNT_W(4), .SKEW_W(8), .MAX_SKEW(2), .HANG_LIMIT(8)
  ) dut (
    .clk(clk), .reset_x(reset_x), .start(start), .init_match(init_match),
    .arch_match(arch_match), .impl_comnum(impl_comnum), .impl_flush(impl_flush),
    .spec_retire(spec_retire), .impl_stall(impl_stall), .spec_stall(spec_stall),
    .aligned(aligned), .check_valid(check_valid), .fail_init(fail_init),
    .fail_mismatch(fail_mismatch), .fail_skew(fail_skew), .fail_hang(fail_hang),
    .state(state), .impl_total(impl_total), .spec_total(spec_total)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; init_match = 0; arch_match = 1; impl_flush = 0;
    spec_retire = 0; impl_comnum = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_x = 0;
    tick();
    tick();
    reset_x = 1;
  endtask

  task automatic go_run();
    start = 1;
    tick();
    start = 0; init_match = 1;
    tick();
    init_match = 0;
  endtask

  // Async reset asserted mid-RUN with skew=+1.
  task automatic test_reset();
    do_reset();
    go_run();
    impl_comnum = 2'd2; spec_retire = 1;
    tick();
    total++; if (impl_stall !== 1'b1) begin bad++; $display("FAIL pre_reset_impl_stall got=%0b want=1", impl_stall); end
    #2 reset_x = 0;
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if ({impl_stall, spec_stall} !== 2'b11) begin bad++; $display("FAIL reset_stalls got=%b want=11", {impl_stall, spec_stall}); end
    total++; if ({impl_total, spec_total} !== 8'h00) begin bad++; $display("FAIL reset_totals got=%h want=00", {impl_total, spec_total}); end
    total++; if ({fail_init, fail_mismatch, fail_skew, fail_hang} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {fail_init, fail_mismatch, fail_skew, fail_hang}); end
    total++; if ({aligned, check_valid} !== 2'b10) begin bad++; $display("FAIL reset_aligned_cv got=%b want=10", {aligned, check_valid}); end
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_hold_state got=%0d want=0", state); end
    reset_x = 1;
  endtask

  // init_match low in CHECK_INIT; start must not leave FAIL.
  task automatic test_init_fail();
    do_reset();
    tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", state); end
    start = 1;
    tick();
    start = 0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL check_init_state got=%0d want=1", state); end
    tick();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL init_fail_state got=%0d want=3", state); end
    total++; if (fail_init !== 1'b1) begin bad++; $display("FAIL fail_init got=%0b want=1", fail_init); end
    total++; if ({impl_stall, spec_stall} !== 2'b11) begin bad++; $display("FAIL init_fail_stalls got=%b want=11", {impl_stall, spec_stall}); end
    start = 1;
    tick();
    start = 0;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL start_in_fail got=%0d want=3", state); end
  endtask

  // Skew +1 then realign; flush; then mismatch freezes totals.
  task automatic test_skew_flush_mismatch();
    do_reset();
    go_run();
    total++; if ({state, impl_stall, spec_stall, check_valid} !== 5'b10001) begin bad++; $display("FAIL run_entry got=%b want=10001", {state, impl_stall, spec_stall, check_valid}); end
    impl_comnum = 2'd2; spec_retire = 1;
    tick();
    total++; if ({impl_stall, spec_stall, aligned} !== 3'b100) begin bad++; $display("FAIL skew_plus_one got=%b want=100", {impl_stall, spec_stall, aligned}); end
    total++; if (check_valid !== 1'b0) begin bad++; $display("FAIL skew_cv got=%0b want=0", check_valid); end
    tick();  // impl stalled: comnum=2 ignored, spec retires
    total++; if ({aligned, check_valid, impl_stall, spec_stall} !== 4'b1100) begin bad++; $display("FAIL realign got=%b want=1100", {aligned, check_valid, impl_stall, spec_stall}); end
    total++; if ({impl_total, spec_total} !== 8'h22) begin bad++; $display("FAIL realign_totals got=%h want=22", {impl_total, spec_total}); end
    impl_flush = 1;
    tick();
    impl_flush = 0;
    total++; if ({impl_total, spec_total} !== 8'h23) begin bad++; $display("FAIL flush_totals got=%h want=23", {impl_total, spec_total}); end
    total++; if ({impl_stall, spec_stall, aligned} !== 3'b010) begin bad++; $display("FAIL flush_stalls got=%b want=010", {impl_stall, spec_stall, aligned}); end
    impl_comnum = 2'd1;
    tick();  // spec stalled: spec_retire ignored
    total++; if ({impl_total, spec_total, aligned} !== 9'h067) begin bad++; $display("FAIL flush_recover got=%h want=067", {impl_total, spec_total, aligned}); end
    impl_comnum = 2'd0; spec_retire = 0; arch_match = 0;
    tick();
    arch_match = 1;
    total++; if ({state, fail_mismatch, check_valid} !== 4'b1110) begin bad++; $display("FAIL mismatch got=%b want=1110", {state, fail_mismatch, check_valid}); end
    total++; if ({fail_skew, fail_hang, fail_init} !== 3'b000) begin bad++; $display("FAIL mismatch_other_flags got=%b want=000", {fail_skew, fail_hang, fail_init}); end
    impl_comnum = 2'd1; spec_retire = 1;
    tick();
    tick();
    total++; if ({impl_total, spec_total, state} !== 10'b0011_0011_11) begin bad++; $display("FAIL frozen got=%b want=0011001111", {impl_total, spec_total, state}); end
    total++; if ({impl_stall, spec_stall} !== 2'b11) begin bad++; $display("FAIL fail_stalls got=%b want=11", {impl_stall, spec_stall}); end
  endtask

  // MAX_SKEW=2: skew 2 is legal, skew 3 fails; mismatch in the same cycle also flags.
  task automatic test_skew_limit();
    do_reset();
    go_run();
    impl_comnum = 2'd3; spec_retire = 1;
    tick();
    total++; if ({state, fail_skew, impl_stall} !== 4'b1001) begin bad++; $display("FAIL skew_at_limit got=%b want=1001", {state, fail_skew, impl_stall}); end
    do_reset();
    go_run();
    impl_comnum = 2'd3; spec_retire = 0; arch_match = 0;
    tick();
    arch_match = 1;
    total++; if ({state, fail_skew, fail_mismatch} !== 4'b1111) begin bad++; $display("FAIL skew_and_mismatch got=%b want=1111", {state, fail_skew, fail_mismatch}); end
    total++; if (impl_total !== 4'd3) begin bad++; $display("FAIL skew_fail_total got=%0d want=3", impl_total); end
  endtask

  // HANG_LIMIT=8 idle RUN cycles.
  task automatic test_hang();
    do_reset();
    go_run();
    for (int i = 0; i < 7; i++) tick();
    total++; if ({state, fail_hang} !== 3'b100) begin bad++; $display("FAIL hang_before got=%b want=100", {state, fail_hang}); end
    tick();
    total++; if ({state, fail_hang} !== 3'b111) begin bad++; $display("FAIL hang got=%b want=111", {state, fail_hang}); end
  endtask

  // 4-bit totals wrap while lockstep stays healthy.
  task automatic test_wrap();
    do_reset();
    go_run();
    impl_comnum = 2'd1; spec_retire = 1;
    for (int i = 0; i < 15; i++) tick();
    total++; if ({impl_total, spec_total} !== 8'hFF) begin bad++; $display("FAIL wrap_max got=%h want=ff", {impl_total, spec_total}); end
    tick();
    total++; if ({impl_total, spec_total} !== 8'h00) begin bad++; $display("FAIL wrap_zero got=%h want=00", {impl_total, spec_total}); end
    tick();
    impl_comnum = 2'd0; spec_retire = 0;
    total++; if ({state, aligned, check_valid, fail_mismatch, fail_skew, fail_hang} !== 7'b1011000) begin bad++; $display("FAIL wrap_status got=%b want=1011000", {state, aligned, check_valid, fail_mismatch, fail_skew, fail_hang}); end
    total++; if ({impl_total, spec_total} !== 8'h11) begin bad++; $display("FAIL wrap_one got=%h want=11", {impl_total, spec_total}); end
  endtask

  initial begin
    reset_x = 0;
    clear_inputs();
    test_reset();
    test_init_fail();
    test_skew_flush_mismatch();
    test_skew_limit();
    test_hang();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_lockstep_commit_scheduler
`default_nettype wire
